// File: rtl/alu_ctrl_seq_pkg.sv
// Shared encodings for the ID/EX ALU controller: ALUOp values, R-type funct codes,
// ALU control codes and the sequencer state type.
package alu_ctrl_seq_pkg;

  localparam logic [2:0] ALU_OP_BEQ  = 3'b001;
  localparam logic [2:0] ALU_OP_R    = 3'b010;
  localparam logic [2:0] ALU_OP_ADDI = 3'b100;
  localparam logic [2:0] ALU_OP_SLTI = 3'b101;
  localparam logic [2:0] ALU_OP_ORI  = 3'b110;

  localparam logic [5:0] ALU_FUNCT_SLL  = 6'h00;
  localparam logic [5:0] ALU_FUNCT_SRL  = 6'h02;
  localparam logic [5:0] ALU_FUNCT_MULT = 6'h18;
  localparam logic [5:0] ALU_FUNCT_ADD  = 6'h20;
  localparam logic [5:0] ALU_FUNCT_SUB  = 6'h22;
  localparam logic [5:0] ALU_FUNCT_AND  = 6'h24;
  localparam logic [5:0] ALU_FUNCT_OR   = 6'h25;
  localparam logic [5:0] ALU_FUNCT_SLT  = 6'h2A;

  localparam logic [3:0] AND_CTRL  = 4'b0000;
  localparam logic [3:0] OR_CTRL   = 4'b0001;
  localparam logic [3:0] ADD_CTRL  = 4'b0010;
  localparam logic [3:0] SUB_CTRL  = 4'b0110;
  localparam logic [3:0] SLT_CTRL  = 4'b0111;
  localparam logic [3:0] SLL_CTRL  = 4'b1000;
  localparam logic [3:0] SRL_CTRL  = 4'b1001;
  localparam logic [3:0] MULT_CTRL = 4'b1010;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_MULTI = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decode. Undecodable ops fall back to ADD and raise illegal_o,
// so every input pattern has a defined result.
module alu_ctrl_decode #(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
) (
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] alu_op_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic               shamt_sel_o,
  output logic               is_multi_o,
  output logic               illegal_o
);
  import alu_ctrl_seq_pkg::*;

  always_comb begin
    ctrl_o      = CTRL_W'(ADD_CTRL);
    shamt_sel_o = 1'b0;
    is_multi_o  = 1'b0;
    illegal_o   = 1'b0;
    case (alu_op_i)
      ALUOP_W'(ALU_OP_R): begin
        case (funct_i)
          FUNCT_W'(ALU_FUNCT_ADD): ctrl_o = CTRL_W'(ADD_CTRL);
          FUNCT_W'(ALU_FUNCT_SUB): ctrl_o = CTRL_W'(SUB_CTRL);
          FUNCT_W'(ALU_FUNCT_AND): ctrl_o = CTRL_W'(AND_CTRL);
          FUNCT_W'(ALU_FUNCT_OR):  ctrl_o = CTRL_W'(OR_CTRL);
          FUNCT_W'(ALU_FUNCT_SLT): ctrl_o = CTRL_W'(SLT_CTRL);
          FUNCT_W'(ALU_FUNCT_SLL): begin
            ctrl_o      = CTRL_W'(SLL_CTRL);
            shamt_sel_o = 1'b1;
          end
          FUNCT_W'(ALU_FUNCT_SRL): begin
            ctrl_o      = CTRL_W'(SRL_CTRL);
            shamt_sel_o = 1'b1;
          end
          FUNCT_W'(ALU_FUNCT_MULT): begin
            ctrl_o     = CTRL_W'(MULT_CTRL);
            is_multi_o = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      ALUOP_W'(ALU_OP_ADDI): ctrl_o = CTRL_W'(ADD_CTRL);
      ALUOP_W'(ALU_OP_SLTI): ctrl_o = CTRL_W'(SLT_CTRL);
      ALUOP_W'(ALU_OP_BEQ):  ctrl_o = CTRL_W'(SUB_CTRL);
      ALUOP_W'(ALU_OP_ORI):  ctrl_o = CTRL_W'(OR_CTRL);
      default:               illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller at the ID/EX boundary: one-cycle decode, multi-cycle MULT
// sequencing with upstream stall, flush and hold handshakes.
//
//   state   | meaning
//   S_IDLE  | accepting ops; single-cycle ops complete on the next edge
//   S_MULTI | MULT in progress; cnt_q counts down to completion, inputs ignored
module alu_ctrl_seq #(
  parameter int FUNCT_W    = 6,
  parameter int ALUOP_W    = 3,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               shamt_sel_o,
  output logic               valid_o,
  output logic               illegal_o,
  output logic               stall_o
);
  import alu_ctrl_seq_pkg::*;

  localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 2);

  if (MUL_CYCLES < 2 || MUL_CYCLES > 255) begin : g_bad_mul_cycles
    $error("alu_ctrl_seq: MUL_CYCLES must be in 2..255");
  end

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_shamt;
  logic              dec_multi;
  logic              dec_illegal;

  alu_ctrl_decode #(
    .FUNCT_W (FUNCT_W),
    .ALUOP_W (ALUOP_W),
    .CTRL_W  (CTRL_W)
  ) u_decode (
    .funct_i     (funct_i),
    .alu_op_i    (ALUOp_i),
    .ctrl_o      (dec_ctrl),
    .shamt_sel_o (dec_shamt),
    .is_multi_o  (dec_multi),
    .illegal_o   (dec_illegal)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              shamt_q, shamt_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      shamt_q   <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      shamt_q   <= shamt_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  // Defaults are the held values, which is exactly what hold_i needs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    shamt_d   = shamt_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!hold_i) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            ctrl_d  = dec_ctrl;
            shamt_d = dec_shamt;
            if (dec_multi) begin
              state_d = S_MULTI;
              cnt_d   = CNT_INIT;
            end else begin
              valid_d   = 1'b1;
              illegal_d = dec_illegal;
            end
          end
        end
        S_MULTI: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign stall_o     = (state_q == S_MULTI) | hold_i;
  assign ALUCtrl_o   = ctrl_q;
  assign shamt_sel_o = shamt_q;
  assign valid_o     = valid_q;
  assign illegal_o   = illegal_q;

  // A wrapped counter would show up as a value above the load value.
  a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CNT_INIT);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: two instances (MUL_CYCLES 4 and 2) share stimulus and are each
// tracked by a behavioural model; table vectors and directed MULT/flush/hold sequences on top.
module tb_alu_ctrl_seq;

  logic       clk_i = 1'b0;
  logic       rst_i, valid_i, hold_i, flush_i;
  logic [5:0] funct_i;
  logic [2:0] aluop_i;

  logic [3:0] ctrl4, ctrl2;
  logic       sh4, sh2, v4, v2, il4, il2, st4, st2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  alu_ctrl_seq #(.FUNCT_W(6), .ALUOP_W(3), .CTRL_W(4), .MUL_CYCLES(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct_i(funct_i), .ALUOp_i(aluop_i),
    .hold_i(hold_i), .flush_i(flush_i), .ALUCtrl_o(ctrl4), .shamt_sel_o(sh4),
    .valid_o(v4), .illegal_o(il4), .stall_o(st4));

  alu_ctrl_seq #(.FUNCT_W(6), .ALUOP_W(3), .CTRL_W(4), .MUL_CYCLES(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct_i(funct_i), .ALUOp_i(aluop_i),
    .hold_i(hold_i), .flush_i(flush_i), .ALUCtrl_o(ctrl2), .shamt_sel_o(sh2),
    .valid_o(v2), .illegal_o(il2), .stall_o(st2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: busy counts the stall cycles still owed by an accepted MULT.
  int         mc [2] = '{4, 2};
  logic [3:0] m_ctrl [2];
  logic       m_sh [2];
  logic       m_v [2];
  logic       m_il [2];
  int         m_busy [2];

  function automatic void ref_decode(input logic [2:0] op, input logic [5:0] f,
                                     output logic [3:0] c, output logic sh,
                                     output logic mu, output logic il);
    c = 4'b0010; sh = 1'b0; mu = 1'b0; il = 1'b0;
    case (op)
      3'b010: case (f)
        6'h20: c = 4'b0010;
        6'h22: c = 4'b0110;
        6'h24: c = 4'b0000;
        6'h25: c = 4'b0001;
        6'h2A: c = 4'b0111;
        6'h00: begin c = 4'b1000; sh = 1'b1; end
        6'h02: begin c = 4'b1001; sh = 1'b1; end
        6'h18: begin c = 4'b1010; mu = 1'b1; end
        default: il = 1'b1;
      endcase
      3'b100: c = 4'b0010;
      3'b101: c = 4'b0111;
      3'b001: c = 4'b0110;
      3'b110: c = 4'b0001;
      default: il = 1'b1;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] c;
    logic sh, mu, il;
    for (int i = 0; i < 2; i++) begin
      if (rst_i) begin
        m_ctrl[i] = 4'b0; m_sh[i] = 1'b0; m_v[i] = 1'b0; m_il[i] = 1'b0; m_busy[i] = 0;
      end else if (flush_i) begin
        m_v[i] = 1'b0; m_il[i] = 1'b0; m_busy[i] = 0;
      end else if (!hold_i) begin
        m_v[i] = 1'b0; m_il[i] = 1'b0;
        if (m_busy[i] > 0) begin
          m_busy[i]--;
          if (m_busy[i] == 0) m_v[i] = 1'b1;
        end else if (valid_i) begin
          ref_decode(aluop_i, funct_i, c, sh, mu, il);
          m_ctrl[i] = c;
          m_sh[i]   = sh;
          if (mu) m_busy[i] = mc[i] - 1;
          else begin
            m_v[i]  = 1'b1;
            m_il[i] = il;
          end
        end
      end
    end
  endtask

  // Inputs are set at the falling edge; stall is checked before the rising edge,
  // registered outputs 1 time unit after it.
  task automatic cycle();
    #1;
    check("stall4_model", st4, (m_busy[0] > 0) || hold_i);
    check("stall2_model", st2, (m_busy[1] > 0) || hold_i);
    @(posedge clk_i);
    model_step();
    #1;
    check("out4_model", {ctrl4, sh4, v4, il4}, {m_ctrl[0], m_sh[0], m_v[0], m_il[0]});
    check("out2_model", {ctrl2, sh2, v2, il2}, {m_ctrl[1], m_sh[1], m_v[1], m_il[1]});
    @(negedge clk_i);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f);
    valid_i = v; aluop_i = op; funct_i = f;
  endtask

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [5:0] f;
    logic [3:0] e_ctrl;
    logic       e_sh;
    logic       e_v;
    logic       e_il;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  c4, c2;
    logic d4, d2;
    logic [2:0] ops [8];
    logic [5:0] fns [9];

    tbl[0]  = '{1'b1, 3'b010, 6'h22, 4'b0110, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 3'b100, 6'h3F, 4'b0010, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 3'b001, 6'h11, 4'b0110, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 3'b010, 6'h00, 4'b1000, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 3'b010, 6'h3F, 4'b0010, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 3'b010, 6'h24, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 3'b010, 6'h25, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 3'b010, 6'h25, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 3'b010, 6'h2A, 4'b0111, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 3'b010, 6'h02, 4'b1001, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 3'b100, 6'h00, 4'b1001, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 3'b101, 6'h00, 4'b0111, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 3'b110, 6'h02, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 3'b111, 6'h20, 4'b0010, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 3'b010, 6'h20, 4'b0010, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 3'b000, 6'h20, 4'b0010, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 2; i++) begin
      m_ctrl[i] = 4'b0; m_sh[i] = 1'b0; m_v[i] = 1'b0; m_il[i] = 1'b0; m_busy[i] = 0;
    end
    rst_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
    drive(1'b1, 3'b010, 6'h20);
    @(posedge clk_i);
    @(negedge clk_i);

    // Reset held two cycles with a valid op present
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("rst_outputs", {ctrl4, sh4, v4, il4}, 7'b0);
      check("rst_stall", st4, 1'b0);
    end
    rst_i = 1'b0;
    cycle();
    check("first_op_valid", v4, 1'b1);
    check("first_op_ctrl", ctrl4, 4'b0010);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].f);
      cycle();
      check("tbl_ctrl", ctrl4, tbl[i].e_ctrl);
      check("tbl_shamt", sh4, tbl[i].e_sh);
      check("tbl_valid", v4, tbl[i].e_v);
      check("tbl_illegal", il4, tbl[i].e_il);
    end

    // Mid-run reset after an SLL clears ctrl and shamt_sel
    drive(1'b1, 3'b010, 6'h00);
    cycle();
    rst_i = 1'b1;
    drive(1'b1, 3'b010, 6'h20);
    cycle();
    cycle();
    check("rst2_outputs", {ctrl4, sh4, v4, il4}, 7'b0);
    rst_i = 1'b0;
    drive(1'b1, 3'b010, 6'h22);
    cycle();
    check("post_rst_op", {ctrl4, v4}, {4'b0110, 1'b1});

    // MULT: 3 stall cycles at MUL_CYCLES=4, 1 at MUL_CYCLES=2
    drive(1'b1, 3'b010, 6'h18);
    cycle();
    check("mult_accept_ctrl", ctrl4, 4'b1010);
    check("mult_accept_valid", v4, 1'b0);
    drive(1'b0, 3'b010, 6'h20);
    c4 = st4 ? 1 : 0; c2 = st2 ? 1 : 0; d4 = 1'b0; d2 = 1'b0;
    for (int k = 0; k < 12 && !(d4 && d2); k++) begin
      cycle();
      if (!d4) begin
        if (st4) c4++;
        else begin d4 = 1'b1; check("mult4_done_valid", v4, 1'b1); end
      end
      if (!d2) begin
        if (st2) c2++;
        else begin d2 = 1'b1; check("mult2_done_valid", v2, 1'b1); end
      end
    end
    check("mult4_finished", d4, 1'b1);
    check("mult2_finished", d2, 1'b1);
    check("mult4_stall_cycles", c4, 3);
    check("mult2_stall_cycles", c2, 1);
    cycle();
    check("mult4_valid_pulse", v4, 1'b0);

    // Flush during the second stall cycle aborts the MULT
    drive(1'b1, 3'b010, 6'h18);
    cycle();
    drive(1'b0, 3'b010, 6'h20);
    cycle();
    check("flush_pre_valid", v4, 1'b0);
    flush_i = 1'b1;
    cycle();
    check("flush_valid", v4, 1'b0);
    flush_i = 1'b0;
    #1;
    check("flush_stall_low", st4, 1'b0);
    drive(1'b1, 3'b010, 6'h20);
    cycle();
    check("flush_next_add", {ctrl4, v4, il4}, {4'b0010, 1'b1, 1'b0});
    drive(1'b0, 3'b010, 6'h20);
    cycle();
    check("flush_no_late_valid", v4, 1'b0);

    // Hold for 3 cycles mid-MULT delays completion by exactly 3 cycles
    drive(1'b1, 3'b010, 6'h18);
    cycle();
    drive(1'b0, 3'b010, 6'h20);
    c4 = st4 ? 1 : 0; d4 = 1'b0;
    cycle();
    if (st4) c4++;
    hold_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("hold_stall", st4, 1'b1);
      check("hold_no_valid", v4, 1'b0);
      if (st4) c4++;
    end
    hold_i = 1'b0;
    for (int k = 0; k < 12 && !d4; k++) begin
      cycle();
      if (st4) c4++;
      else begin d4 = 1'b1; check("hold_done_valid", v4, 1'b1); end
    end
    check("hold_finished", d4, 1'b1);
    check("hold_stall_cycles", c4, 6);

    // Hold and flush together: flush wins
    drive(1'b1, 3'b010, 6'h18);
    cycle();
    drive(1'b0, 3'b010, 6'h20);
    hold_i = 1'b1; flush_i = 1'b1;
    cycle();
    check("holdflush_valid", v4, 1'b0);
    hold_i = 1'b0; flush_i = 1'b0;
    #1;
    check("holdflush_stall_low", st4, 1'b0);
    drive(1'b1, 3'b100, 6'h00);
    cycle();
    check("holdflush_next", {ctrl4, v4}, {4'b0010, 1'b1});

    // Randomised traffic against the model
    ops = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b101, 3'b001, 3'b110, 3'b000};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h18, 6'h00};
    for (int k = 0; k < 400; k++) begin
      rst_i   = ($urandom_range(0, 99) < 2);
      flush_i = ($urandom_range(0, 99) < 8);
      hold_i  = ($urandom_range(0, 99) < 15);
      valid_i = ($urandom_range(0, 99) < 70);
      aluop_i = ($urandom_range(0, 7) == 7) ? 3'($urandom) : ops[$urandom_range(0, 6)];
      funct_i = ($urandom_range(0, 8) == 8) ? 6'($urandom) : fns[$urandom_range(0, 7)];
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
